otter_target_gen: RTL and testbench
===================================

# otter_target_gen

Registered, parametrised control-transfer target generator for the OTTER fetch/execute boundary. Each cycle it can accept one JAL, JALR or branch request and computes the target in XLEN-bit modulo arithmetic, clearing bit 0 for JALR. One cycle later it presents the target together with a misalignment flag. It also keeps a return-address stack (RAS) that predicts JALR returns and reports return mispredictions to the PC logic.

## Interface
Parameters:
- XLEN, 32, datapath and address width.
- RAS_DEPTH, 4, number of RAS entries; a power of two, at least 2.
- IALIGN, 32, instruction alignment in bits; the only legal values are 32 and 16.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  request present this cycle.
- i_flush  in  1  kill the request in the same cycle and clear the output stage.
- i_addr_gen_sel  in  2  request kind: 2'b00 JAL, 2'b01 JALR, 2'b10 BRANCH, 2'b11 none.
- i_rfile_r_rs1  in  XLEN  rs1 value (used by JALR).
- i_immed  in  XLEN  sign-extended immediate.
- i_pc_addr  in  XLEN  PC of the requesting instruction.
- i_rd_link  in  1  rd is x1 or x5.
- i_rs1_link  in  1  rs1 is x1 or x5.
- o_valid  out  1  output stage holds a result.
- o_dest_addr  out  XLEN  computed target.
- o_misaligned  out  1  the target violates IALIGN.
- o_ras_pred  out  XLEN  RAS prediction that was used for this JALR.
- o_ras_mispredict  out  1  a RAS prediction was used and it differs from o_dest_addr.
- o_ras_count  out  $clog2(RAS_DEPTH)+1  current number of RAS entries.

## Operation
- A request is accepted when i_valid && !i_flush && sel != 2'b11. Any other cycle loads o_valid=0.
- Target computation:
  - JAL and BRANCH: tgt = i_pc_addr + i_immed.
  - JALR: tgt = (i_rfile_r_rs1 + i_immed) & ~1.
  - All sums are truncated to XLEN bits, so wrap-around is silent.
- Misalignment:
  - IALIGN=32: misaligned = tgt[1].
  - IALIGN=16: misaligned is always 0.
  - A misaligned request still registers its target, but the RAS is never updated for it.
- RAS action for an accepted, aligned request. link = pc + (IALIGN==32 ? 4 : 2), mod 2^XLEN.
  - JAL with rd_link: push link.
  - JALR, rd_link=0, rs1_link=1: pop.
  - JALR, rd_link=1, rs1_link=0: push.
  - JALR, both set: pop then push, implemented as replacing the top. If the RAS is empty, this is a push only.
  - BRANCH, or neither link flag set: no RAS action.
- RAS storage:
  - Circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Pop when empty changes nothing and produces no prediction.
- Prediction:
  - On any JALR that pops a non-empty RAS (including replace-top), o_ras_pred = the old top.
  - o_ras_mispredict = (old top != tgt).
  - Otherwise both o_ras_pred and o_ras_mispredict are 0.
- Flush: i_flush has priority over i_valid. The request is discarded, with no RAS change. On the same edge the output stage loads o_valid=0 and o_ras_mispredict=0.

## Timing
- Latency is 1 cycle: a request accepted at edge N is presented on the outputs after edge N, for exactly one cycle.
- Throughput is one request per cycle. There is no backpressure, so the consumer samples outputs whenever o_valid=1.
- The RAS update takes effect at the acceptance edge. A JALR in the very next cycle therefore sees the pushed entry.
- When o_valid=0, o_dest_addr, o_misaligned, o_ras_pred and o_ras_mispredict are all 0.
- Reset (asynchronous assert, release synchronous to i_clk):
  - All outputs go to 0 and o_ras_count goes to 0.
  - RAS contents are don't-care.
  - If reset asserts mid-sequence, the pending result is lost and the RAS is emptied.

## Test plan
- JAL at pc=0x100 with immed=0x20 and rd_link=1 -> next cycle o_valid=1, o_dest_addr=0x120, o_ras_count=1. Then JALR with rs1=0x104, immed=0 and rs1_link=1 -> o_dest_addr=0x104, o_ras_pred=0x104, o_ras_mispredict=0, o_ras_count=0.
- JALR with rs1=0x203 and immed=0 (IALIGN=32) -> o_dest_addr=0x202, o_misaligned=1, and o_ras_count unchanged.
- Push 5 links (pcs 0x0, 0x10, 0x20, 0x30, 0x40) with RAS_DEPTH=4 -> count saturates at 4. Four returns predict 0x44, 0x34, 0x24, 0x14. A fifth return gives o_ras_pred=0, o_ras_mispredict=0, count 0.
- BRANCH with pc=0xFFFF_FFF0 and immed=0x20 -> o_dest_addr=0x0000_0010, no RAS action.
- i_valid=1 and i_flush=1 with a JAL that has rd_link=1 -> o_valid=0 next cycle and o_ras_count unchanged. Asserting i_rst_n=0 asynchronously mid-stream -> all outputs 0 immediately.
- Return-prediction mismatch: RAS top=0x104, then JALR to rs1=0x200 with rs1_link=1 -> o_ras_pred=0x104, o_ras_mispredict=1.

Source files
------------

// File: rtl/otter_target_gen.sv
// otter_target_gen: registered control-transfer target generator with a
// return-address stack. It computes JAL/BRANCH/JALR targets, flags
// misalignment and predicts JALR returns from a circular RAS.
module otter_target_gen #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int IALIGN    = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    input  logic                           i_flush,
    input  logic [1:0]                     i_addr_gen_sel,
    input  logic [XLEN-1:0]                i_rfile_r_rs1,
    input  logic [XLEN-1:0]                i_immed,
    input  logic [XLEN-1:0]                i_pc_addr,
    input  logic                           i_rd_link,
    input  logic                           i_rs1_link,
    output logic                           o_valid,
    output logic [XLEN-1:0]                o_dest_addr,
    output logic                           o_misaligned,
    output logic [XLEN-1:0]                o_ras_pred,
    output logic                           o_ras_mispredict,
    output logic [$clog2(RAS_DEPTH):0]     o_ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] SEL_JAL  = 2'b00;
    localparam logic [1:0] SEL_JALR = 2'b01;
    localparam logic [1:0] SEL_BR   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Link address step is one instruction of the configured alignment.
    localparam logic [XLEN-1:0] LINK_INC = (IALIGN == 32) ? XLEN'(4) : XLEN'(2);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]   top_r;
    logic [CW-1:0]   count_r;

    logic            accept_s;
    logic [XLEN-1:0] pc_sum_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] tgt_s;
    logic            mis_s;
    logic [XLEN-1:0] link_s;
    logic            push_s;
    logic            pop_s;
    logic [PW-1:0]   top_inc_s;
    logic [PW-1:0]   top_dec_s;
    logic [PW-1:0]   wr_idx_s;
    logic [XLEN-1:0] top_val_s;

    assign o_ras_count = count_r;

    // Target, misalignment and link address for the current request.
    always_comb begin
        accept_s   = i_valid && !i_flush && (i_addr_gen_sel != SEL_NONE);
        pc_sum_s   = i_pc_addr + i_immed;
        jalr_sum_s = i_rfile_r_rs1 + i_immed;
        link_s     = i_pc_addr + LINK_INC;
        case (i_addr_gen_sel)
            SEL_JALR: tgt_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            SEL_JAL:  tgt_s = pc_sum_s;
            SEL_BR:   tgt_s = pc_sum_s;
            default:  tgt_s = pc_sum_s;
        endcase
        if (IALIGN == 32) begin
            mis_s = tgt_s[1];
        end else begin
            mis_s = 1'b0;
        end
    end

    // RAS action decode: a pop with a push is a replace-top; a pop on an
    // empty stack degenerates to nothing (or a plain push when linking).
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (accept_s && !mis_s) begin
            case (i_addr_gen_sel)
                SEL_JAL: begin
                    push_s = i_rd_link;
                end
                SEL_JALR: begin
                    pop_s  = i_rs1_link && (count_r != {CW{1'b0}});
                    push_s = i_rd_link;
                end
                default: begin
                    push_s = 1'b0;
                    pop_s  = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    always_comb begin
        top_inc_s = top_r + PW'(1);
        top_dec_s = top_r - PW'(1);
        top_val_s = ras_mem_r[top_r];
        if (pop_s) begin
            wr_idx_s = top_r;
        end else begin
            wr_idx_s = top_inc_s;
        end
    end

    // RAS storage; contents are don't-care after reset, only the count matters.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            ras_mem_r[wr_idx_s] <= link_s;
        end
    end

    // RAS top pointer and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            top_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (push_s && pop_s) begin
            top_r   <= top_r;
            count_r <= count_r;
        end else if (push_s) begin
            top_r   <= top_inc_s;
            count_r <= (count_r == DEPTH_C) ? count_r : count_r + CW'(1);
        end else if (pop_s) begin
            top_r   <= top_dec_s;
            count_r <= count_r - CW'(1);
        end
    end

    // Output stage: one-cycle presentation of the accepted request, zero otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid          <= 1'b0;
            o_dest_addr      <= {XLEN{1'b0}};
            o_misaligned     <= 1'b0;
            o_ras_pred       <= {XLEN{1'b0}};
            o_ras_mispredict <= 1'b0;
        end else begin
            o_valid          <= accept_s;
            o_dest_addr      <= accept_s ? tgt_s : {XLEN{1'b0}};
            o_misaligned     <= accept_s && mis_s;
            o_ras_pred       <= pop_s ? top_val_s : {XLEN{1'b0}};
            o_ras_mispredict <= pop_s && (top_val_s != tgt_s);
        end
    end

endmodule

// File: tb/tb_otter_target_gen.sv
// Self-checking bench for otter_target_gen: directed scenarios plus a
// randomized run against a queue-based return-address-stack model.
module tb_otter_target_gen;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic [1:0]  sel;
    logic [31:0] rs1;
    logic [31:0] immed;
    logic [31:0] pc;
    logic        rd_link;
    logic        rs1_link;
    logic        o_valid;
    logic [31:0] o_dest_addr;
    logic        o_misaligned;
    logic [31:0] o_ras_pred;
    logic        o_ras_mispredict;
    logic [2:0]  o_ras_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ras_q[$];
    logic        exp_valid;
    logic [31:0] exp_dest;
    logic        exp_mis;
    logic [31:0] exp_pred;
    logic        exp_mp;

    otter_target_gen #(.XLEN(32), .RAS_DEPTH(4), .IALIGN(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_valid          (valid),
        .i_flush          (flush),
        .i_addr_gen_sel   (sel),
        .i_rfile_r_rs1    (rs1),
        .i_immed          (immed),
        .i_pc_addr        (pc),
        .i_rd_link        (rd_link),
        .i_rs1_link       (rs1_link),
        .o_valid          (o_valid),
        .o_dest_addr      (o_dest_addr),
        .o_misaligned     (o_misaligned),
        .o_ras_pred       (o_ras_pred),
        .o_ras_mispredict (o_ras_mispredict),
        .o_ras_count      (o_ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, update the model, clock it in and sample #1 later.
    task automatic step(input logic v, input logic f, input logic [1:0] s,
                        input logic [31:0] r, input logic [31:0] im,
                        input logic [31:0] p, input logic rdl, input logic r1l);
        logic [31:0] tgt;
        logic [31:0] sum;
        valid = v; flush = f; sel = s; rs1 = r; immed = im; pc = p;
        rd_link = rdl; rs1_link = r1l;
        exp_valid = 1'b0; exp_dest = 32'd0; exp_mis = 1'b0;
        exp_pred = 32'd0; exp_mp = 1'b0;
        if (v && !f && s != 2'b11) begin
            if (s == 2'b01) begin
                sum = r + im;
                tgt = sum & 32'hFFFF_FFFE;
            end else begin
                tgt = p + im;
            end
            exp_valid = 1'b1;
            exp_dest  = tgt;
            exp_mis   = tgt[1];
            if (!exp_mis) begin
                if (s == 2'b00 && rdl) begin
                    ras_q.push_back(p + 32'd4);
                end else if (s == 2'b01) begin
                    if (r1l && ras_q.size() > 0) begin
                        exp_pred = ras_q[$];
                        exp_mp   = (exp_pred != tgt);
                        void'(ras_q.pop_back());
                    end
                    if (rdl) ras_q.push_back(p + 32'd4);
                end
                if (ras_q.size() > 4) ras_q.delete(0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0 || o_dest_addr !== 32'd0 || o_misaligned !== 1'b0 ||
            o_ras_pred !== 32'd0 || o_ras_mispredict !== 1'b0 || o_ras_count !== 3'd0) begin
            failures++;
            $display("FAIL reset: valid=%0b dest=%h mis=%0b pred=%h mp=%0b cnt=%0d expected all 0",
                     o_valid, o_dest_addr, o_misaligned, o_ras_pred, o_ras_mispredict, o_ras_count);
        end
    endtask

    task automatic test_jal_jalr();
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'h20, 32'h100, 1'b1, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_dest_addr !== 32'h120 || o_ras_count !== 3'd1) begin
            failures++;
            $display("FAIL jal_push: valid=%0b dest=%h cnt=%0d expected 1 00000120 1",
                     o_valid, o_dest_addr, o_ras_count);
        end
        step(1'b1, 1'b0, 2'b01, 32'h104, 32'd0, 32'h120, 1'b0, 1'b1);
        checks++;
        if (o_dest_addr !== 32'h104 || o_ras_pred !== 32'h104 ||
            o_ras_mispredict !== 1'b0 || o_ras_count !== 3'd0) begin
            failures++;
            $display("FAIL jalr_return: dest=%h pred=%h mp=%0b cnt=%0d expected 00000104 00000104 0 0",
                     o_dest_addr, o_ras_pred, o_ras_mispredict, o_ras_count);
        end
        idle();
        checks++;
        if (o_valid !== 1'b0 || o_dest_addr !== 32'd0 || o_ras_pred !== 32'd0) begin
            failures++;
            $display("FAIL idle_zero: valid=%0b dest=%h pred=%h expected 0 0 0",
                     o_valid, o_dest_addr, o_ras_pred);
        end
    endtask

    task automatic test_misaligned();
        step(1'b1, 1'b0, 2'b01, 32'h203, 32'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_dest_addr !== 32'h202 || o_misaligned !== 1'b1 || o_ras_count !== 3'd0) begin
            failures++;
            $display("FAIL misaligned: dest=%h mis=%0b cnt=%0d expected 00000202 1 0",
                     o_dest_addr, o_misaligned, o_ras_count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] want;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 2'b00, 32'd0, 32'h40, 32'(i * 16), 1'b1, 1'b0);
        checks++;
        if (o_ras_count !== 3'd4) begin
            failures++;
            $display("FAIL ras_saturate: cnt=%0d expected 4", o_ras_count);
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'h44 - 32'(i * 16);
            step(1'b1, 1'b0, 2'b01, want, 32'd0, 32'h800, 1'b0, 1'b1);
            checks++;
            if (o_ras_pred !== want || o_ras_mispredict !== 1'b0 || o_ras_count !== 3'(3 - i)) begin
                failures++;
                $display("FAIL ras_pop%0d: pred=%h mp=%0b cnt=%0d expected %h 0 %0d",
                         i, o_ras_pred, o_ras_mispredict, o_ras_count, want, 3 - i);
            end
        end
        step(1'b1, 1'b0, 2'b01, 32'h14, 32'd0, 32'h800, 1'b0, 1'b1);
        checks++;
        if (o_ras_pred !== 32'd0 || o_ras_mispredict !== 1'b0 || o_ras_count !== 3'd0) begin
            failures++;
            $display("FAIL ras_empty_pop: pred=%h mp=%0b cnt=%0d expected 0 0 0",
                     o_ras_pred, o_ras_mispredict, o_ras_count);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 2'b10, 32'd0, 32'h20, 32'hFFFF_FFF0, 1'b1, 1'b1);
        checks++;
        if (o_dest_addr !== 32'h10 || o_ras_count !== 3'd0 || o_ras_pred !== 32'd0) begin
            failures++;
            $display("FAIL branch_wrap: dest=%h cnt=%0d pred=%h expected 00000010 0 0",
                     o_dest_addr, o_ras_count, o_ras_pred);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'h8, 32'h300, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'b00, 32'd0, 32'h8, 32'h400, 1'b1, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_dest_addr !== 32'd0 || o_ras_count !== 3'd1) begin
            failures++;
            $display("FAIL flush: valid=%0b dest=%h cnt=%0d expected 0 0 1",
                     o_valid, o_dest_addr, o_ras_count);
        end
        step(1'b1, 1'b1, 2'b01, 32'h999, 32'd0, 32'h400, 1'b0, 1'b1);
        checks++;
        if (o_ras_mispredict !== 1'b0 || o_ras_count !== 3'd1) begin
            failures++;
            $display("FAIL flush_jalr: mp=%0b cnt=%0d expected 0 1", o_ras_mispredict, o_ras_count);
        end
    endtask

    task automatic test_mispredict();
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'h20, 32'h100, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'b01, 32'h200, 32'd0, 32'h120, 1'b0, 1'b1);
        checks++;
        if (o_ras_pred !== 32'h104 || o_ras_mispredict !== 1'b1 || o_dest_addr !== 32'h200) begin
            failures++;
            $display("FAIL mispredict: pred=%h mp=%0b dest=%h expected 00000104 1 00000200",
                     o_ras_pred, o_ras_mispredict, o_dest_addr);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 2'b00, 32'd0, 32'h10, 32'h500, 1'b1, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_dest_addr !== 32'd0 || o_ras_count !== 3'd0 ||
            o_ras_pred !== 32'd0 || o_misaligned !== 1'b0 || o_ras_mispredict !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%0b dest=%h cnt=%0d expected 0 0 0",
                     o_valid, o_dest_addr, o_ras_count);
        end
        ras_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        v, f, rdl, r1l;
        logic [1:0]  s;
        logic [31:0] r, im, p;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 9) != 0);
            f   = ($urandom_range(0, 9) == 0);
            s   = 2'($urandom_range(0, 3));
            rdl = 1'($urandom_range(0, 1));
            r1l = 1'($urandom_range(0, 1));
            p   = $urandom & 32'hFFFF_FFFC;
            im  = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) im = im | 32'd2;
            if (ras_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                r  = ras_q[$];
                im = 32'd0;
            end else begin
                r = $urandom;
            end
            step(v, f, s, r, im, p, rdl, r1l);
            checks++;
            if (o_valid !== exp_valid || o_dest_addr !== exp_dest || o_misaligned !== exp_mis ||
                o_ras_pred !== exp_pred || o_ras_mispredict !== exp_mp ||
                o_ras_count !== 3'(ras_q.size())) begin
                failures++;
                $display("FAIL random[%0d]: got v=%0b d=%h m=%0b p=%h mp=%0b c=%0d want v=%0b d=%h m=%0b p=%h mp=%0b c=%0d",
                         n, o_valid, o_dest_addr, o_misaligned, o_ras_pred, o_ras_mispredict, o_ras_count,
                         exp_valid, exp_dest, exp_mis, exp_pred, exp_mp, ras_q.size());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; sel = 2'b11;
        rs1 = 32'd0; immed = 32'd0; pc = 32'd0; rd_link = 1'b0; rs1_link = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_jal_jalr();
        test_misaligned();
        test_overflow();
        test_wrap();
        test_flush();
        test_mispredict();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
